// File: rtl/display_pkg.sv
`default_nettype none
// ============================================================================
// Module      : display_pkg
// Description : Shared constants for the pipeline display driver: source
//               select codes, active-low seven-segment encoding table and
//               blank/off patterns, plus the source multiplexer helper.
// Revision    : 1.0 - initial release
// ============================================================================
package display_pkg;

    // Source select codes driven on Sel
    localparam logic [1:0] SEL_PC = 2'd0;
    localparam logic [1:0] SEL_WD = 2'd1;
    localparam logic [1:0] SEL_HI = 2'd2;
    localparam logic [1:0] SEL_LO = 2'd3;

    // All segments dark / all digits disabled (active-low)
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [7:0] AN_OFF    = 8'hFF;

    // Active-low {g,f,e,d,c,b,a} patterns for hex digits 0..F
    localparam logic [6:0] SEG_TABLE [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    // Choose the observed processor value for a given select code
    function automatic logic [31:0] pick_source(
        input logic [1:0]  sel,
        input logic [31:0] pc,
        input logic [31:0] wd,
        input logic [31:0] hi,
        input logic [31:0] lo
    );
        logic [31:0] result;
        case (sel)
            SEL_PC:  result = pc;
            SEL_WD:  result = wd;
            SEL_HI:  result = hi;
            default: result = lo;
        endcase
        return result;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pipeline_display_driver_hex_to_seg.sv
`default_nettype none
// ============================================================================
// Module      : hex_to_seg
// Description : Combinational 4-bit nibble to active-low seven-segment
//               ({g,f,e,d,c,b,a}) decoder.
// Revision    : 1.0 - initial release
// ============================================================================
module hex_to_seg
    import display_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    // Table lookup; every nibble value has an entry so no default is needed
    assign seg = SEG_TABLE[nibble];

endmodule
`default_nettype wire

// File: rtl/pipeline_display_driver.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_display_driver
// Description : Samples one of four processor observation words at a slow
//               rate and scans its eight hex nibbles across a multiplexed
//               8-digit active-low seven-segment display. A status LED is
//               held on for a while after the shown value changes.
//               Optional macro LEADING_ZERO_BLANK_EN blanks leading zero
//               digits (digit 0 is always shown).
// Revision    : 1.0 - initial release
// ============================================================================
module pipeline_display_driver
    import display_pkg::*;
#(
    parameter int SCAN_DIV    = 100000,
    parameter int SAMPLE_DIV  = 10000000,
    parameter int CHANGE_HOLD = 25000000
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic [31:0] PCValue,
    input  logic [31:0] WriteData,
    input  logic [31:0] HiData,
    input  logic [31:0] LoData,
    input  logic [1:0]  Sel,
    input  logic        Freeze,
    output logic [7:0]  Anodes,
    output logic [6:0]  Segments,
    output logic        ChangeLed
);

    localparam int SCAN_W   = $clog2(SCAN_DIV);
    localparam int SAMPLE_W = $clog2(SAMPLE_DIV);
    localparam int HOLD_W   = $clog2(CHANGE_HOLD + 1);

    localparam logic [SCAN_W-1:0]   c_scan_last   = SCAN_W'(SCAN_DIV - 1);
    localparam logic [SAMPLE_W-1:0] c_sample_last = SAMPLE_W'(SAMPLE_DIV - 1);
    localparam logic [HOLD_W-1:0]   c_hold_init   = HOLD_W'(CHANGE_HOLD);

    logic [SCAN_W-1:0]   r_scan_cnt;
    logic [2:0]          r_digit;
    logic [SAMPLE_W-1:0] r_sample_cnt;
    logic [HOLD_W-1:0]   r_hold_cnt;
    logic [31:0]         r_disp;
    logic [1:0]          r_prev_sel;
    logic [7:0]          r_anodes;
    logic [6:0]          r_segments;
    logic                r_change_led;

    logic [31:0] w_source;
    logic        w_scan_wrap;
    logic        w_tick;
    logic        w_sel_change;
    logic        w_capture;
    logic        w_changed;
    logic [3:0]  w_nibble;
    logic [6:0]  w_seg;
    logic        w_blank;

    assign w_source    = pick_source(Sel, PCValue, WriteData, HiData, LoData);
    assign w_scan_wrap = (r_scan_cnt == c_scan_last);
    assign w_tick      = (r_sample_cnt == c_sample_last);

    // A select change is only acted on while unfrozen; PrevSel keeps the old
    // code during a freeze so the pending change is caught once it lifts.
    assign w_sel_change = (Sel != r_prev_sel) && !Freeze;
    // Tick and select change on the same edge merge into one capture
    assign w_capture    = !Freeze && (w_tick || w_sel_change);
    assign w_changed    = w_capture && (w_source != r_disp);

`ifdef LEADING_ZERO_BLANK_EN
    logic [31:0] w_upper;
    assign w_upper  = r_disp >> {r_digit, 2'b00};
    assign w_nibble = w_upper[3:0];
    // Blank a non-zero position when it and every nibble above it are zero
    assign w_blank  = (r_digit != 3'd0) && (w_upper == 32'd0);
`else
    assign w_nibble = r_disp[{r_digit, 2'b00} +: 4];
    assign w_blank  = 1'b0;
`endif

    hex_to_seg u_hex_to_seg (
        .nibble (w_nibble),
        .seg    (w_seg)
    );

    // Digit scan: hold each digit for SCAN_DIV cycles, then advance mod 8
    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_scan_cnt <= '0;
            r_digit    <= 3'd0;
        end else if (w_scan_wrap) begin
            r_scan_cnt <= '0;
            r_digit    <= r_digit + 3'd1;
        end else begin
            r_scan_cnt <= r_scan_cnt + SCAN_W'(1);
        end
    end

    // Sample timer: free-running, restarted by an accepted select change
    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_sample_cnt <= '0;
        end else if (w_tick || w_sel_change) begin
            r_sample_cnt <= '0;
        end else begin
            r_sample_cnt <= r_sample_cnt + SAMPLE_W'(1);
        end
    end

    // Displayed value and the select code it was taken from
    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_disp     <= 32'd0;
            r_prev_sel <= SEL_PC;
        end else begin
            if (w_capture) begin
                r_disp <= w_source;
            end
            if (w_sel_change) begin
                r_prev_sel <= Sel;
            end
        end
    end

    // Change-hold timer and its registered LED
    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_hold_cnt   <= '0;
            r_change_led <= 1'b0;
        end else begin
            if (w_changed) begin
                r_hold_cnt <= c_hold_init;
            end else if (r_hold_cnt != '0) begin
                r_hold_cnt <= r_hold_cnt - HOLD_W'(1);
            end
            r_change_led <= (r_hold_cnt != '0);
        end
    end

    // Registered digit drive: one active-low anode plus its segment pattern
    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_anodes   <= AN_OFF;
            r_segments <= SEG_BLANK;
        end else if (w_blank) begin
            r_anodes   <= AN_OFF;
            r_segments <= SEG_BLANK;
        end else begin
            r_anodes   <= ~(8'b0000_0001 << r_digit);
            r_segments <= w_seg;
        end
    end

    assign Anodes    = r_anodes;
    assign Segments  = r_segments;
    assign ChangeLed = r_change_led;

endmodule
`default_nettype wire

// File: tb/tb_pipeline_display_driver.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipeline_display_driver
// Description : Directed self-checking bench for pipeline_display_driver
//               (SCAN_DIV=2, SAMPLE_DIV=16, CHANGE_HOLD=5). Expected display
//               values are queued when driven and compared against the value
//               reconstructed from one full scan of Anodes/Segments.
//               Honours LEADING_ZERO_BLANK_EN when defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipeline_display_driver;

`ifdef LEADING_ZERO_BLANK_EN
    localparam bit BLANK_EN = 1'b1;
`else
    localparam bit BLANK_EN = 1'b0;
`endif

    logic        Clk = 1'b0;
    logic        Rst = 1'b1;
    logic [31:0] PCValue = 32'd0;
    logic [31:0] WriteData = 32'd0;
    logic [31:0] HiData = 32'd0;
    logic [31:0] LoData = 32'd0;
    logic [1:0]  Sel = 2'd0;
    logic        Freeze = 1'b0;
    logic [7:0]  Anodes;
    logic [6:0]  Segments;
    logic        ChangeLed;

    int total = 0;
    int bad   = 0;
    logic [31:0] sb_q [$];

    logic [6:0]  rd_segs [8];
    logic [7:0]  rd_seen;
    logic [31:0] rd_val;
    logic        rd_led;
    int          rd_badpat;

    always #5 Clk = ~Clk;

    pipeline_display_driver #(
        .SCAN_DIV    (2),
        .SAMPLE_DIV  (16),
        .CHANGE_HOLD (5)
    ) dut (
        .Clk       (Clk),
        .Rst       (Rst),
        .PCValue   (PCValue),
        .WriteData (WriteData),
        .HiData    (HiData),
        .LoData    (LoData),
        .Sel       (Sel),
        .Freeze    (Freeze),
        .Anodes    (Anodes),
        .Segments  (Segments),
        .ChangeLed (ChangeLed)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [4:0] seg2hex(input logic [6:0] s);
        case (s)
            7'h40: return {1'b1, 4'h0};
            7'h79: return {1'b1, 4'h1};
            7'h24: return {1'b1, 4'h2};
            7'h30: return {1'b1, 4'h3};
            7'h19: return {1'b1, 4'h4};
            7'h12: return {1'b1, 4'h5};
            7'h02: return {1'b1, 4'h6};
            7'h78: return {1'b1, 4'h7};
            7'h00: return {1'b1, 4'h8};
            7'h10: return {1'b1, 4'h9};
            7'h08: return {1'b1, 4'hA};
            7'h03: return {1'b1, 4'hB};
            7'h46: return {1'b1, 4'hC};
            7'h21: return {1'b1, 4'hD};
            7'h06: return {1'b1, 4'hE};
            7'h0E: return {1'b1, 4'hF};
            default: return 5'd0;
        endcase
    endfunction

    // Watch one full scan (16 cycles + margin) and rebuild the shown word
    task read_display();
        logic [4:0] d;
        int idx;
        int nz;
        rd_seen   = 8'h00;
        rd_led    = 1'b0;
        rd_badpat = 0;
        for (int i = 0; i < 8; i++) rd_segs[i] = 7'h7F;
        for (int k = 0; k < 18; k++) begin
            @(negedge Clk);
            if (ChangeLed) rd_led = 1'b1;
            if (Anodes != 8'hFF) begin
                idx = 0;
                nz  = 0;
                for (int b = 0; b < 8; b++) begin
                    if (!Anodes[b]) begin
                        nz++;
                        idx = b;
                    end
                end
                if (nz == 1) begin
                    rd_seen[idx] = 1'b1;
                    rd_segs[idx] = Segments;
                end else begin
                    rd_badpat++;
                end
            end
        end
        rd_val = 32'd0;
        for (int i = 0; i < 8; i++) begin
            if (rd_seen[i]) begin
                d = seg2hex(rd_segs[i]);
                rd_val[i*4 +: 4] = d[4] ? d[3:0] : 4'bxxxx;
            end
        end
    endtask

    task check_display(input string tag);
        logic [31:0] e;
        read_display();
        if (sb_q.size() == 0) begin
            total++;
            bad++;
            $error("FAIL %s observed=empty-scoreboard expected=entry", tag);
        end else begin
            e = sb_q.pop_front();
            chk(tag, rd_val, e);
        end
        chk({tag, "_anode_onehot"}, rd_badpat, 0);
    endtask

    initial begin
        int d;
        int w;
        int len;
        logic [7:0] one;
        logic [7:0] exp_an;
        one = 8'b0000_0001;

        // ---------------- Reset ----------------
        for (int k = 0; k < 3; k++) begin
            @(negedge Clk);
            chk("rst_anodes", Anodes, 8'hFF);
            chk("rst_segments", Segments, 7'h7F);
            chk("rst_led", ChangeLed, 1'b0);
        end
        Rst = 1'b0;
        chk("post_rst_anodes", Anodes, 8'hFF);
        chk("post_rst_segments", Segments, 7'h7F);
        for (int k = 1; k <= 18; k++) begin
            @(negedge Clk);
            d = ((k - 1) / 2) % 8;
            exp_an = (BLANK_EN && d != 0) ? 8'hFF : ~(one << d);
            chk("scan_anodes", Anodes, exp_an);
        end
        chk("scan_led", ChangeLed, 1'b0);

        // ---------------- Periodic sample of PCValue ----------------
        PCValue = 32'h0040_00A8;
        sb_q.push_back(32'h0040_00A8);
        w = 0;
        while (!ChangeLed && w < 24) begin
            @(negedge Clk);
            w++;
        end
        chk("pc_led_rise", ChangeLed, 1'b1);
        len = 1;
        for (int k = 0; k < 20; k++) begin
            @(negedge Clk);
            if (!ChangeLed) break;
            len++;
        end
        chk("pc_led_len", len, 5);
        check_display("pc_value");
        chk("pc_digit0", rd_segs[0], 7'h00);
        chk("pc_digit1", rd_segs[1], 7'h08);
        chk("pc_digit2", rd_segs[2], 7'h40);
        chk("pc_digit5", rd_segs[5], 7'h19);

        // ---------------- Select change mid-interval ----------------
        HiData = 32'hDEAD_BEEF;
        Sel    = 2'd2;
        sb_q.push_back(32'hDEAD_BEEF);
        for (int j = 1; j <= 8; j++) begin
            @(negedge Clk);
            chk("sel_led_pulse", ChangeLed, (j >= 2 && j <= 6) ? 1'b1 : 1'b0);
        end
        check_display("hi_value");
        chk("hi_digit7", rd_segs[7], 7'h21);
        repeat (5) @(negedge Clk);
        HiData = 32'hDEAD_BEE0;
        sb_q.push_back(32'hDEAD_BEE0);
        @(negedge Clk);
        @(negedge Clk);
        chk("restart_before_tick", ChangeLed, 1'b0);
        @(negedge Clk);
        chk("restart_on_tick", ChangeLed, 1'b1);
        repeat (6) @(negedge Clk);
        check_display("hi_value2");

        // ---------------- Freeze ----------------
        Freeze  = 1'b1;
        PCValue = 32'h1234_5678;
        LoData  = 32'hCAFE_0123;
        Sel     = 2'd3;
        sb_q.push_back(32'hDEAD_BEE0);
        for (int k = 0; k < 22; k++) begin
            @(negedge Clk);
            chk("freeze_led", ChangeLed, 1'b0);
        end
        check_display("freeze_value");
        chk("freeze_led_scan", rd_led, 1'b0);
        Freeze = 1'b0;
        sb_q.push_back(32'hCAFE_0123);
        @(negedge Clk);
        @(negedge Clk);
        chk("unfreeze_capture", ChangeLed, 1'b1);
        repeat (6) @(negedge Clk);
        check_display("lo_value");

        // ---------------- Identical value on successive ticks ----------------
        for (int k = 0; k < 40; k++) begin
            @(negedge Clk);
            chk("steady_led", ChangeLed, 1'b0);
        end

        // ---------------- Rapid changes keep the LED on ----------------
        PCValue = 32'h1111_1111;
        for (int k = 0; k < 30; k++) begin
            if (k % 3 == 0) Sel = (Sel == 2'd3) ? 2'd0 : 2'd3;
            @(negedge Clk);
            if (k + 1 >= 2) chk("rapid_led", ChangeLed, 1'b1);
        end
        repeat (8) @(negedge Clk);

        // ---------------- Leading zeros ----------------
        Sel     = 2'd0;
        PCValue = 32'h0000_0012;
        sb_q.push_back(32'h0000_0012);
        repeat (3) @(negedge Clk);
        check_display("small_value");
        chk("small_seen_mask", rd_seen, BLANK_EN ? 8'h03 : 8'hFF);
        PCValue = 32'h0000_0000;
        sb_q.push_back(32'h0000_0000);
        w = 0;
        while (!ChangeLed && w < 24) begin
            @(negedge Clk);
            w++;
        end
        chk("zero_led_rise", ChangeLed, 1'b1);
        repeat (7) @(negedge Clk);
        check_display("zero_value");
        chk("zero_seen_mask", rd_seen, BLANK_EN ? 8'h01 : 8'hFF);
        chk("zero_digit0", rd_segs[0], 7'h40);

        chk("scoreboard_drained", sb_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/pipeline_display_driver.md
Name: pipeline_display_driver

Overview:
- Consumes the processor's architectural observation outputs (PCValue, WriteData, HiData, LoData) and drives an 8-digit, time-multiplexed seven-segment display.
- Samples one selected 32-bit value at a slow, fixed rate and scans its eight hex nibbles across the display.
- Flags value changes on a status LED.
- Sits directly downstream of the processor top level on the FPGA board wrapper.

Parameters:
- SCAN_DIV, 100000: clock cycles each digit stays lit; must be ≥ 2.
- SAMPLE_DIV, 10000000: clock cycles between periodic samples of the selected source; must be ≥ 2.
- CHANGE_HOLD, 25000000: clock cycles ChangeLed stays high after a change is detected; must be ≥ 1.

Ports:
- Clk  in  1  system clock, shared with the processor.
- Rst  in  1  synchronous, active-high reset.
- PCValue  in  32  current PC from the processor.
- WriteData  in  32  write-back data from the processor.
- HiData  in  32  Hi register value.
- LoData  in  32  Lo register value.
- Sel  in  2  source select: 0=PCValue, 1=WriteData, 2=HiData, 3=LoData.
- Freeze  in  1  when high, blocks all sampling; the display keeps its current value.
- Anodes  out  8  active-low digit enables; bit i drives digit i, where digit 0 is the rightmost digit and shows nibble [3:0].
- Segments  out  7  active-low segments {g,f,e,d,c,b,a}.
- ChangeLed  out  1  high while the change-hold timer is running.

Behaviour:
- Clock and reset: one clock, Clk. Reset Rst is synchronous and active-high; all state updates on the rising edge of Clk.
- Reset values:
  - DispReg=0, PrevSel=0, digit index=0.
  - scan_cnt=0, sample_cnt=0, hold_cnt=0.
  - Anodes=8'hFF, Segments=7'h7F, ChangeLed=0.
  - Freeze and Sel are ignored while Rst is high.
- Scan counter:
  - scan_cnt counts 0..SCAN_DIV-1 and wraps.
  - On the wrap cycle, the digit index increments modulo 8 (7→0).
- Sample counter:
  - sample_cnt counts 0..SAMPLE_DIV-1 and wraps.
  - The wrap cycle is the sample tick.
- Capture rules:
  - On a sample tick with Freeze=0, DispReg <= mux(Sel).
  - When Sel != PrevSel and Freeze=0, DispReg <= mux(Sel) immediately (same edge), sample_cnt restarts at 0, and PrevSel <= Sel.
  - A Sel change and a sample tick on the same cycle produce a single capture.
  - While Freeze=1: PrevSel is not updated, so a Sel change made while frozen is captured on the first cycle after Freeze falls. Counters keep running.
- Change detection:
  - On any capture where the new value != DispReg, hold_cnt <= CHANGE_HOLD. A new change during the hold reloads it.
  - Otherwise hold_cnt decrements while nonzero and saturates at 0.
  - ChangeLed = registered (hold_cnt != 0).
- Output generation:
  - Anodes and Segments are registered and reflect the digit index and DispReg with 1-cycle latency.
  - Exactly one anode is low at any time after the first post-reset cycle, except for digits blanked by the optional feature.
- Hex encoding (active-low, gfedcba):
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78
  - 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E

Optional Feature:
- Macro: LEADING_ZERO_BLANK_EN.
- Defined:
  - A digit i>0 is blanked when all nibbles at and above i in DispReg are zero.
  - For a blanked digit, Anodes stays 8'hFF and Segments stays 7'h7F for that digit's slot.
  - Digit 0 is never blanked, so 0 displays as a single "0".
- Undefined: all 8 digits are always shown, including leading zeros.
- Scan timing is identical in both builds.

Decomposition:
- Shared package display_pkg holds:
  - source-select constants SEL_PC, SEL_WD, SEL_HI, SEL_LO;
  - the 16-entry segment encoding table;
  - constants SEG_BLANK=7'h7F and AN_OFF=8'hFF.
- One natural sub-module: hex_to_seg, a combinational 4-bit nibble → 7-bit active-low segment decoder, instantiated once on the muxed nibble.

Test Plan (SCAN_DIV=2, SAMPLE_DIV=16, CHANGE_HOLD=5):
- Reset for 3 cycles, then release → during reset and on the first cycle after release: Anodes=FF, Segments=7F, ChangeLed=0; afterwards Anodes steps FE,FD,FB,…,7F,FE every 2 cycles.
- Sel=0, PCValue=32'h0040_00A8, wait for a sample tick → digit 0 shows 00 ("8"), digit 1 shows 08 ("A"), digit 2 shows 40 ("0"), digit 5 shows 19 ("4"); ChangeLed is high for exactly 5 cycles.
- Sel 0→2 with HiData=32'hDEAD_BEEF mid-interval → DispReg=DEADBEEF on the next edge, sample_cnt=0, digit 7 shows 21 ("d"), ChangeLed reloads to 5.
- Freeze=1, change PCValue and Sel=3, hold Freeze for 40 cycles → DispReg unchanged and ChangeLed=0 throughout; on Freeze release, LoData is captured within 1 cycle.
- Capture of an identical value on successive ticks → ChangeLed stays 0. Change the source value every 3 cycles → ChangeLed stays continuously high.
- LEADING_ZERO_BLANK_EN with DispReg=32'h0000_0012 → only digits 0 and 1 ever drive a low anode. With DispReg=0 → only digit 0 is lit and shows 40.
